// File: rtl/ffe_weight_loader.sv
// FFE weight loader: walks every (lane, tap), reads its weight from an
// external table and writes it through the wme inst/data/exec strobe.
//
// Ports:
//   clk, rstb             clock, async active-low reset
//   start, abort          begin a full load / stop a load in progress
//   setup/exec/hold_cycles  strobe spacing, 0 treated as 1
//   wt_raddr, wt_rdata    weight table read port {w_idx, d_idx}
//   wme_ffe_inst/data/exec  write interface to the weight manager
//   busy, done, aborted   load status
module ffe_weight_loader #(
  parameter int LENGTH           = 10,
  parameter int CHANNEL_WIDTH    = 16,
  parameter int WEIGHT_PRECISION = 10,
  parameter int DW               = $clog2(LENGTH),
  parameter int WW               = $clog2(CHANNEL_WIDTH),
  parameter int CNT_W            = 16
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            setup_cycles,
  input  logic [CNT_W-1:0]            exec_cycles,
  input  logic [CNT_W-1:0]            hold_cycles,
  output logic [WW+DW-1:0]            wt_raddr,
  input  logic [WEIGHT_PRECISION-1:0] wt_rdata,
  output logic [WW+DW:0]              wme_ffe_inst,
  output logic [WEIGHT_PRECISION-1:0] wme_ffe_data,
  output logic                        wme_ffe_exec,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SETUP,
    S_EXEC,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [DW-1:0] D_LAST = DW'(LENGTH - 1);
  localparam logic [WW-1:0] W_LAST = WW'(CHANNEL_WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_ld;
  logic [DW-1:0]    d_idx;
  logic [WW-1:0]    w_idx;
  logic             last;

  function automatic logic [CNT_W-1:0] clamp1(
    input logic [CNT_W-1:0] v
  );
    return (v == '0) ? ONE : v;
  endfunction

  assign last     = (d_idx == D_LAST) && (w_idx == W_LAST);
  assign wt_raddr = {w_idx, d_idx};

  always_comb begin
    nxt     = state;
    cnt_ld  = 1'b0;
    cnt_val = '0;
    unique case (state)
      S_IDLE: if (start) nxt = S_READ;
      S_READ: begin
        nxt     = S_SETUP;
        cnt_ld  = 1'b1;
        cnt_val = clamp1(setup_cycles);
      end
      S_SETUP: if (cnt == ONE) begin
        nxt     = S_EXEC;
        cnt_ld  = 1'b1;
        cnt_val = clamp1(exec_cycles);
      end
      S_EXEC: if (cnt == ONE) begin
        nxt     = S_HOLD;
        cnt_ld  = 1'b1;
        cnt_val = clamp1(hold_cycles);
      end
      S_HOLD: if (cnt == ONE) begin
        nxt = last ? S_DONE : S_READ;
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      nxt    = S_IDLE;
      cnt_ld = 1'b0;
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      state == S_DONE: done = 1'b1;
      state == S_IDLE: busy = 1'b0;
      default:         busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state        <= S_IDLE;
      cnt          <= '0;
      d_idx        <= '0;
      w_idx        <= '0;
      wme_ffe_inst <= '0;
      wme_ffe_data <= '0;
      wme_ffe_exec <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= nxt;
      wme_ffe_exec <= (nxt == S_EXEC);
      if (cnt_ld) begin
        cnt <= cnt_val;
      end else if (cnt > ONE) begin
        cnt <= cnt - ONE;
      end
      if (state == S_IDLE && start) begin
        d_idx   <= '0;
        w_idx   <= '0;
        aborted <= 1'b0;
      end
      if (state != S_IDLE && abort) begin
        aborted <= 1'b1;
      end
      if (state == S_READ && nxt == S_SETUP) begin
        wme_ffe_data <= wt_rdata;
        wme_ffe_inst <= {1'b0, w_idx, d_idx};
      end
      // Tap is the inner loop; the final weight rewinds to (0,0).
      if (state == S_HOLD && (nxt == S_READ || nxt == S_DONE)) begin
        if (d_idx == D_LAST) begin
          d_idx <= '0;
          w_idx <= (w_idx == W_LAST) ? '0 : w_idx + WW'(1);
        end else begin
          d_idx <= d_idx + DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ffe_weight_loader.sv
// Bench for ffe_weight_loader: a 2x2 and a 3x3 instance checked against
// a per-weight timing and content model.
module tb_ffe_weight_loader;

  logic clk;
  logic rstb;
  logic st [2];
  logic ab [2];
  logic [15:0] sc [2];
  logic [15:0] ec [2];
  logic [15:0] hc [2];

  logic [1:0] raddr_a;
  logic [2:0] inst_a;
  logic [9:0] rd_a, data_a;
  logic exec_a, busy_a, done_a, abt_a;
  logic [3:0] raddr_b;
  logic [4:0] inst_b;
  logic [9:0] rd_b, data_b;
  logic exec_b, busy_b, done_b, abt_b;

  logic [9:0] tbl [2][9];

  ffe_weight_loader #(.LENGTH(2), .CHANNEL_WIDTH(2)) dut_a (
    .clk(clk), .rstb(rstb), .start(st[0]), .abort(ab[0]),
    .setup_cycles(sc[0]), .exec_cycles(ec[0]),
    .hold_cycles(hc[0]), .wt_raddr(raddr_a), .wt_rdata(rd_a),
    .wme_ffe_inst(inst_a), .wme_ffe_data(data_a),
    .wme_ffe_exec(exec_a), .busy(busy_a), .done(done_a),
    .aborted(abt_a));

  ffe_weight_loader #(.LENGTH(3), .CHANNEL_WIDTH(3)) dut_b (
    .clk(clk), .rstb(rstb), .start(st[1]), .abort(ab[1]),
    .setup_cycles(sc[1]), .exec_cycles(ec[1]),
    .hold_cycles(hc[1]), .wt_raddr(raddr_b), .wt_rdata(rd_b),
    .wme_ffe_inst(inst_b), .wme_ffe_data(data_b),
    .wme_ffe_exec(exec_b), .busy(busy_b), .done(done_b),
    .aborted(abt_b));

  // Table content k is weight (w = k / LENGTH, d = k % LENGTH).
  always_comb rd_a = tbl[0][raddr_a];
  always_comb begin
    rd_b = 10'h155;
    if (raddr_b[3:2] < 2'd3 && raddr_b[1:0] < 2'd3)
      rd_b = tbl[1][int'(raddr_b[3:2]) * 3 + int'(raddr_b[1:0])];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic exec_v [2];
  logic busy_v [2];
  logic done_v [2];
  int   inst_v [2];
  int   data_v [2];
  assign exec_v[0] = exec_a;
  assign exec_v[1] = exec_b;
  assign busy_v[0] = busy_a;
  assign busy_v[1] = busy_b;
  assign done_v[0] = done_a;
  assign done_v[1] = done_b;
  assign inst_v[0] = int'(inst_a);
  assign inst_v[1] = int'(inst_b);
  assign data_v[0] = int'(data_a);
  assign data_v[1] = int'(data_b);

  int n_rise [2];
  int rise_t [2][512];
  int rise_i [2][512];
  int rise_d [2][512];
  int n_wid [2];
  int wid [2][512];
  int wcnt [2];
  logic prev [2];
  int n_done [2];
  int done_t [2];
  int busy_n [2];
  int unstable [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (exec_v[i] && !prev[i]) begin
        rise_t[i][n_rise[i] % 512] <= cyc;
        rise_i[i][n_rise[i] % 512] <= inst_v[i];
        rise_d[i][n_rise[i] % 512] <= data_v[i];
        n_rise[i] <= n_rise[i] + 1;
        wcnt[i] <= 1;
      end else if (exec_v[i]) begin
        wcnt[i] <= wcnt[i] + 1;
        if (inst_v[i] != rise_i[i][(n_rise[i] - 1) % 512] ||
            data_v[i] != rise_d[i][(n_rise[i] - 1) % 512])
          unstable[i] <= unstable[i] + 1;
      end
      if (!exec_v[i] && prev[i]) begin
        wid[i][n_wid[i] % 512] <= wcnt[i];
        n_wid[i] <= n_wid[i] + 1;
      end
      if (done_v[i]) begin
        n_done[i] <= n_done[i] + 1;
        done_t[i] <= cyc;
      end
      if (busy_v[i]) busy_n[i] <= busy_n[i] + 1;
      prev[i] <= exec_v[i];
    end
  end

  int n_cmp;
  int n_bad;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int cl(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // One full load on instance id; the model predicts every strobe.
  task automatic run_load(input int id, input int s, input int e,
                          input int h, input bit mid_start,
                          output int ts, output int br);
    int len, dwb, n, p, bw, bd, bb, bu, rs, rw, k;
    len = (id == 0) ? 2 : 3;
    dwb = (id == 0) ? 1 : 2;
    n   = len * len;
    sc[id] = 16'(s);
    ec[id] = 16'(e);
    hc[id] = 16'(h);
    p = 1 + cl(s) + cl(e) + cl(h);
    @(negedge clk);
    ts = cyc;
    br = n_rise[id];
    bw = n_wid[id];
    bd = n_done[id];
    bb = busy_n[id];
    bu = unstable[id];
    st[id] = 1'b1;
    @(negedge clk);
    st[id] = 1'b0;
    chk("busy_after_start", int'(busy_v[id]), 1);
    chk("aborted_cleared",
        int'((id == 0) ? abt_a : abt_b), 0);
    for (int c = 0; c < n * p + 20 && n_done[id] == bd; c++) begin
      @(negedge clk);
      st[id] = (mid_start && cyc == ts + p + 2) ? 1'b1 : 1'b0;
    end
    st[id] = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_count", n_done[id] - bd, 1);
    chk("done_time", done_t[id] - ts, n * p + 1);
    chk("busy_cycles", busy_n[id] - bb, n * p);
    chk("pulse_count", n_rise[id] - br, n);
    chk("stable_while_exec", unstable[id] - bu, 0);
    for (k = 0; k < n; k++) begin
      rs = rise_t[id][(br + k) % 512] - ts;
      chk($sformatf("rise_t[%0d]", k), rs,
          2 + cl(s) + k * p);
      chk($sformatf("inst[%0d]", k), rise_i[id][(br + k) % 512],
          ((k / len) << dwb) | (k % len));
      chk($sformatf("data[%0d]", k), rise_d[id][(br + k) % 512],
          int'(tbl[id][k]));
      rw = wid[id][(bw + k) % 512];
      chk($sformatf("width[%0d]", k), rw, cl(e));
    end
  endtask

  typedef struct {
    int s;
    int e;
    int h;
    int exp_width;
    int exp_period;
    int exp_done;
    int exp_busy;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ts, br, bd, bb, br2;
    vecs[0] = '{2, 1, 2, 1, 6, 25, 24};
    vecs[1] = '{0, 0, 0, 1, 4, 17, 16};
    vecs[2] = '{1, 3, 1, 3, 6, 25, 24};
    vecs[3] = '{3, 2, 0, 2, 7, 29, 28};
    n_cmp = 0;
    n_bad = 0;
    rstb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      ab[i] = 1'b0;
      sc[i] = '0;
      ec[i] = '0;
      hc[i] = '0;
      for (int k = 0; k < 9; k++) tbl[i][k] = 10'(k * 37 + 11);
    end
    tbl[0][0] = 10'd3;
    tbl[0][1] = 10'h3FB;
    tbl[0][2] = 10'd7;
    tbl[0][3] = 10'd9;
    repeat (2) @(negedge clk);
    chk("rst_exec", int'(exec_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_aborted", int'(abt_a), 0);
    chk("rst_inst", int'(inst_a), 0);
    chk("rst_data", int'(data_a), 0);
    chk("rst_raddr", int'(raddr_a), 0);
    chk("rst_b_busy", int'(busy_b), 0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      bb = busy_n[0];
      run_load(0, vecs[v].s, vecs[v].e, vecs[v].h, 1'b0, ts, br);
      chk($sformatf("vec%0d_width", v), wid[0][br % 512],
          vecs[v].exp_width);
      chk($sformatf("vec%0d_period", v),
          rise_t[0][(br + 1) % 512] - rise_t[0][br % 512],
          vecs[v].exp_period);
      chk($sformatf("vec%0d_done", v), done_t[0] - ts,
          vecs[v].exp_done);
      chk($sformatf("vec%0d_busy", v), busy_n[0] - bb,
          vecs[v].exp_busy);
    end

    // Abort in the second EXEC cycle of weight (1,0).
    sc[0] = 16'd2;
    ec[0] = 16'd3;
    hc[0] = 16'd2;
    @(negedge clk);
    ts = cyc;
    br = n_rise[0];
    bd = n_done[0];
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    for (int c = 0; c < 100 && cyc < ts + 21; c++) @(negedge clk);
    chk("abort_in_exec", int'(exec_a), 1);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    chk("abort_exec_low", int'(exec_a), 0);
    chk("abort_busy_low", int'(busy_a), 0);
    chk("abort_sticky", int'(abt_a), 1);
    chk("abort_inst_kept", int'(inst_a), 2);
    chk("abort_data_kept", int'(data_a), 7);
    repeat (40) @(negedge clk);
    chk("abort_pulses", n_rise[0] - br, 3);
    chk("abort_last_width", wid[0][(br + 2) % 512], 2);
    chk("abort_no_done", n_done[0] - bd, 0);
    chk("abort_still_set", int'(abt_a), 1);
    run_load(0, 2, 1, 2, 1'b0, ts, br);

    // start while busy is ignored.
    run_load(0, 1, 2, 1, 1'b1, ts, br);
    run_load(1, 2, 1, 1, 1'b1, ts, br);

    // Reset asserted during SETUP.
    sc[0] = 16'd2;
    ec[0] = 16'd1;
    hc[0] = 16'd1;
    @(negedge clk);
    ts = cyc;
    br2 = n_rise[0];
    bd = n_done[0];
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("mid_rst_exec", int'(exec_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_inst", int'(inst_a), 0);
    chk("mid_rst_data", int'(data_a), 0);
    chk("mid_rst_aborted", int'(abt_a), 0);
    @(negedge clk);
    rstb = 1'b1;
    bb = busy_n[0];
    repeat (30) @(negedge clk);
    chk("post_rst_pulses", n_rise[0] - br2, 0);
    chk("post_rst_done", n_done[0] - bd, 0);
    chk("post_rst_busy", busy_n[0] - bb, 0);

    // Randomized loads on both instances.
    for (int r = 0; r < 8; r++) begin
      int id;
      id = r % 2;
      for (int k = 0; k < 9; k++) tbl[id][k] = 10'($urandom);
      run_load(id, int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
               ts, br);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
